// File: rtl/multicycle_exec.sv
// multicycle_exec: multi-cycle MIPS-subset execution unit.
// One instruction is accepted over a valid/ready handshake and stepped through
// DECODE -> EXEC -> (MEM) -> WB. Owns the register file, ALU, sign-extend and PC.
// Data memory is reached over a req/ack handshake with variable latency.
// Optional build macro: MULTICYCLE_OVF_TRAP_EN adds the ovf_trap output and
// suppresses the register write on signed overflow of add/sub/addi.
module multicycle_exec #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    input  logic [31:0]       ins,
    output logic              ins_ready,
    output logic [PC_W-1:0]   pc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              retire,
    output logic              illegal,
`ifdef MULTICYCLE_OVF_TRAP_EN
    output logic              ovf_trap,
`endif
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {K_RTYPE, K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_t;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_SLT} alu_t;

    state_t state, state_n;
    kind_t  kind_d, kind_q;
    alu_t   alu_op_d, alu_op_q;

    logic [31:0]       ins_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q, res_q;
    logic [DATA_W-1:0] imm_sext, opnd_b, alu_res;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [PC_W-1:0]   pc_q, br_off;
    logic              taken_q;
    logic [4:0]        dest;
    logic              wen;
    logic              unused_shamt;

    logic [DATA_W-1:0] regs [NREGS];

`ifdef MULTICYCLE_OVF_TRAP_EN
    logic ovf, ovf_q;
`endif

    // Register index 0 and indices beyond the implemented file read as zero.
    function automatic logic [DATA_W-1:0] rd_reg(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NREGS) return '0;
        return regs[idx];
    endfunction

    assign imm_sext     = DATA_W'({{DATA_W{ins_q[15]}}, ins_q[15:0]});
    assign br_off       = PC_W'({{PC_W{ins_q[15]}}, ins_q[15:0], 2'b00});
    assign opnd_b       = (kind_q == K_RTYPE) ? b_q : imm_q;
    assign unused_shamt = ^ins_q[10:6];

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic: memory ops detour through MEM until acked.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        state_n = state;
        case (state)
            S_IDLE:   if (ins_valid) state_n = S_DECODE;
            S_DECODE: state_n = S_EXEC;
            S_EXEC:   state_n = (kind_q == K_LW || kind_q == K_SW) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) state_n = S_WB;
            S_WB:     state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Classify the latched instruction word.
    always_comb begin
        kind_d   = K_ILL;
        alu_op_d = A_ADD;
        case (ins_q[31:26])
            6'h00: begin
                kind_d = K_RTYPE;
                case (ins_q[5:0])
                    6'h20:   alu_op_d = A_ADD;
                    6'h22:   alu_op_d = A_SUB;
                    6'h24:   alu_op_d = A_AND;
                    6'h25:   alu_op_d = A_OR;
                    6'h2A:   alu_op_d = A_SLT;
                    default: kind_d   = K_ILL;
                endcase
            end
            6'h08:   kind_d = K_ADDI;
            6'h23:   kind_d = K_LW;
            6'h2B:   kind_d = K_SW;
            6'h04:   kind_d = K_BEQ;
            default: kind_d = K_ILL;
        endcase
    end

    // ALU: R-type ops, or rs + sext(imm) for addi and memory addresses.
    always_comb begin
        alu_res = a_q + opnd_b;
        if (kind_q == K_RTYPE) begin
            case (alu_op_q)
                A_SUB:   alu_res = a_q - b_q;
                A_AND:   alu_res = a_q & b_q;
                A_OR:    alu_res = a_q | b_q;
                A_SLT:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
                default: alu_res = a_q + b_q;
            endcase
        end
    end

`ifdef MULTICYCLE_OVF_TRAP_EN
    // Signed overflow: operands agree in sign (inverted b for sub) but the result does not.
    always_comb begin
        ovf = 1'b0;
        if (kind_q == K_ADDI || (kind_q == K_RTYPE && alu_op_q == A_ADD))
            ovf = (a_q[DATA_W-1] == opnd_b[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
        else if (kind_q == K_RTYPE && alu_op_q == A_SUB)
            ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    end
`endif

    // Write-back destination: rd for R-type, rt for addi/lw, none otherwise.
    always_comb begin
        dest = ins_q[20:16];
        wen  = 1'b0;
        case (kind_q)
            K_RTYPE: begin dest = ins_q[15:11]; wen = 1'b1; end
            K_ADDI,
            K_LW:    wen = 1'b1;
            default: wen = 1'b0;
        endcase
`ifdef MULTICYCLE_OVF_TRAP_EN
        if (ovf_q) wen = 1'b0;
`endif
    end

    // Per-stage datapath registers and PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ins_q    <= '0;
            kind_q   <= K_RTYPE;
            alu_op_q <= A_ADD;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            taken_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
`ifdef MULTICYCLE_OVF_TRAP_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (ins_valid) ins_q <= ins;
                S_DECODE: begin
                    a_q      <= rd_reg(ins_q[25:21]);
                    b_q      <= rd_reg(ins_q[20:16]);
                    imm_q    <= imm_sext;
                    kind_q   <= kind_d;
                    alu_op_q <= alu_op_d;
                end
                S_EXEC: begin
                    res_q   <= alu_res;
                    taken_q <= (a_q == b_q);
`ifdef MULTICYCLE_OVF_TRAP_EN
                    ovf_q   <= ovf;
`endif
                    if (kind_q == K_LW || kind_q == K_SW) begin
                        addr_q  <= alu_res;
                        wdata_q <= b_q;
                    end
                end
                S_MEM: if (dmem_ack && kind_q == K_LW) res_q <= dmem_rdata;
                S_WB: begin
                    if (kind_q == K_BEQ && taken_q) pc_q <= pc_q + PC_W'(4) + br_off;
                    else                           pc_q <= pc_q + PC_W'(4);
                end
                default: ;
            endcase
        end
    end

    // Register file; index 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is architecturally cleared on reset, so every entry is reset here.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == S_WB && wen && dest != 5'd0 && int'(dest) < NREGS) begin
            regs[dest] <= res_q;
        end
    end

    assign ins_ready  = (state == S_IDLE);
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = dmem_req && (kind_q == K_SW);
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign retire     = (state == S_WB);
    assign illegal    = retire && (kind_q == K_ILL);
    assign pc         = pc_q;
    assign dbg_data   = rd_reg(dbg_addr);
`ifdef MULTICYCLE_OVF_TRAP_EN
    assign ovf_trap   = retire && ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_exec.sv
// tb_multicycle_exec: directed and randomized checks of multicycle_exec against
// an instruction-level reference model (register array, PC, memory map).
module tb_multicycle_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ins_valid = 1'b0;
    logic [31:0] ins = '0;
    logic        ins_ready;
    logic [31:0] pc;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        retire, illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
`ifdef MULTICYCLE_OVF_TRAP_EN
    logic        ovf_trap;
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    multicycle_exec #(.DATA_W(32), .NREGS(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready), .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .retire(retire), .illegal(illegal),
`ifdef MULTICYCLE_OVF_TRAP_EN
        .ovf_trap(ovf_trap),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_mem [logic [31:0]];

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : 32'd0;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0;
    endtask

    // Compare every architectural register through the debug port.
    task automatic check_regs(input string tag);
        int bad;
        int first;
        logic [31:0] got;
        bad = 0;
        first = -1;
        got = '0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            if (dbg_data !== m_regs[i]) begin
                if (first < 0) begin first = i; got = dbg_data; end
                bad++;
            end
        end
        n_total++;
        if (bad != 0)
            $display("FAIL %s regfile: %0d regs differ, r%0d got %h want %h",
                     tag, bad, first, got, m_regs[first]);
        else n_pass++;
    endtask

    // Issue one instruction, service memory with 'lat' wait cycles, check timing and results.
    task automatic run_instr(input logic [31:0] w, input int lat, input string tag);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, dst;
        logic [31:0] a, b, se, res, exp_addr, exp_pc;
        longint      s;
        bit          is_mem, is_st, ill, wr, ovf, bad, got_ill, got_ovf;
        int          exp_ret, ret_c, c, waits;

        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
        a = m_regs[rs]; b = m_regs[rt];
        se = {{16{w[15]}}, w[15:0]};
        is_mem = 0; is_st = 0; ill = 0; wr = 0; ovf = 0;
        res = '0; dst = '0; exp_addr = '0; s = 0;
        exp_pc = m_pc + 32'd4;
        case (op)
            6'h00: begin
                dst = rd; wr = 1;
                case (fn)
                    6'h20: begin res = a + b; s = longint'($signed(a)) + longint'($signed(b)); end
                    6'h22: begin res = a - b; s = longint'($signed(a)) - longint'($signed(b)); end
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin ill = 1; wr = 0; end
                endcase
                if (fn == 6'h20 || fn == 6'h22) ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h08: begin
                dst = rt; wr = 1; res = a + se;
                s = longint'($signed(a)) + longint'($signed(se));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h23: begin is_mem = 1; exp_addr = a + se; dst = rt; wr = 1; res = mem_rd(exp_addr); end
            6'h2B: begin is_mem = 1; is_st = 1; exp_addr = a + se; end
            6'h04: if (a == b) exp_pc = m_pc + 32'd4 + (se << 2);
            default: ill = 1;
        endcase
        exp_ret = is_mem ? 4 + lat : 3;

        @(negedge clk);
        n_total++;
        if (ins_ready !== 1'b1) $display("FAIL %s ready_idle: got %b want 1", tag, ins_ready);
        else n_pass++;
        ins_valid = 1'b1;
        ins = w;
        @(posedge clk);
        @(negedge clk);
        c = 1; waits = 0; ret_c = -1; bad = 0; got_ill = 0; got_ovf = 0;
        while (ret_c < 0 && c <= 40) begin
            ins_valid = 1'($urandom_range(0, 1));
            ins = $urandom;
            dmem_ack = 1'b0;
            if (ins_ready !== 1'b0) bad = 1;
            if (retire === 1'b1) begin
                ret_c = c;
                got_ill = illegal;
`ifdef MULTICYCLE_OVF_TRAP_EN
                got_ovf = ovf_trap;
`endif
                if (dmem_req === 1'b1) bad = 1;
            end else begin
                if (illegal === 1'b1) bad = 1;
                if (dmem_req === 1'b1) begin
                    if (!is_mem || dmem_we !== is_st || dmem_addr !== exp_addr ||
                        (is_st && dmem_wdata !== b)) bad = 1;
                    if (waits == lat) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = is_st ? $urandom : mem_rd(exp_addr);
                    end
                    waits++;
                end else begin
                    dmem_ack = ($urandom_range(0, 3) == 0);
                end
                @(negedge clk);
                c++;
            end
        end
        ins_valid = 1'b0;
        dmem_ack = 1'b0;

        n_total++;
        if (ret_c != exp_ret) $display("FAIL %s retire_cycle: got %0d want %0d", tag, ret_c, exp_ret);
        else n_pass++;
        n_total++;
        if (got_ill !== ill) $display("FAIL %s illegal: got %b want %b", tag, got_ill, ill);
        else n_pass++;
        n_total++;
        if (bad) $display("FAIL %s protocol: got violation want none", tag);
        else n_pass++;
`ifdef MULTICYCLE_OVF_TRAP_EN
        n_total++;
        if (got_ovf !== ovf) $display("FAIL %s ovf_trap: got %b want %b", tag, got_ovf, ovf);
        else n_pass++;
`endif

        if (wr && dst != 5'd0 && !(OVF_EN && ovf)) m_regs[dst] = res;
        if (is_st) m_mem[exp_addr] = b;
        m_pc = exp_pc;

        @(negedge clk);
        n_total++;
        if (pc !== m_pc) $display("FAIL %s pc: got %h want %h", tag, pc, m_pc);
        else n_pass++;
        check_regs(tag);
    endtask

    task automatic test_reset;
        #1;
        n_total++;
        if (pc !== 32'd0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'd0 ||
            dmem_wdata !== 32'd0 || retire !== 1'b0 || illegal !== 1'b0)
            $display("FAIL reset_outputs: got pc=%h req=%b we=%b addr=%h wd=%h ret=%b ill=%b want all 0",
                     pc, dmem_req, dmem_we, dmem_addr, dmem_wdata, retire, illegal);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_total++;
        if (ins_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ins_ready);
        else n_pass++;
        check_regs("reset");
    endtask

    task automatic test_alu;
        run_instr(32'h20010005, 0, "addi_r1");
        run_instr(32'h00211020, 0, "add_r2");
        dbg_addr = 5'd2;
        #1;
        n_total++;
        if (dbg_data !== 32'd10 || pc !== 32'd8)
            $display("FAIL add_r2_direct: got r2=%0d pc=%h want r2=10 pc=8", dbg_data, pc);
        else n_pass++;
        run_instr(i_ins(6'h08, 5'd0, 5'd3, 16'hFFFF), 0, "addi_neg");
        run_instr(r_ins(5'd3, 5'd1, 5'd4, 6'h2A), 0, "slt");
        run_instr(r_ins(5'd1, 5'd3, 5'd5, 6'h22), 0, "sub");
        run_instr(r_ins(5'd1, 5'd3, 5'd7, 6'h24), 0, "and");
        run_instr(r_ins(5'd1, 5'd4, 5'd8, 6'h25), 0, "or");
    endtask

    task automatic test_mem;
        run_instr(i_ins(6'h2B, 5'd0, 5'd1, 16'h0004), 3, "sw_wait3");
        run_instr(i_ins(6'h23, 5'd0, 5'd6, 16'h0004), 0, "lw_zero_wait");
        dbg_addr = 5'd6;
        #1;
        n_total++;
        if (dbg_data !== 32'd5) $display("FAIL lw_r6_direct: got %0d want 5", dbg_data);
        else n_pass++;
        run_instr(i_ins(6'h23, 5'd1, 5'd9, 16'hFFFF), 2, "lw_neg_off");
    endtask

    task automatic test_branch;
        run_instr(i_ins(6'h04, 5'd1, 5'd1, 16'h0002), 0, "beq_taken");
        run_instr(i_ins(6'h04, 5'd1, 5'd0, 16'h0002), 0, "beq_not_taken");
        run_instr(i_ins(6'h04, 5'd0, 5'd0, 16'hFFFD), 0, "beq_backward");
    endtask

    task automatic test_illegal_r0;
        run_instr(32'hFC000000, 0, "illegal_op");
        run_instr(r_ins(5'd1, 5'd1, 5'd10, 6'h21), 0, "illegal_funct");
        run_instr(i_ins(6'h08, 5'd0, 5'd0, 16'h0007), 0, "addi_r0");
        dbg_addr = 5'd0;
        #1;
        n_total++;
        if (dbg_data !== 32'd0) $display("FAIL r0_zero: got %h want 0", dbg_data);
        else n_pass++;
    endtask

    task automatic test_overflow;
        m_mem[32'h100] = 32'h7FFFFFFF;
        run_instr(i_ins(6'h23, 5'd0, 5'd10, 16'h0100), 1, "lw_max");
        run_instr(i_ins(6'h08, 5'd0, 5'd11, 16'h0001), 0, "addi_one");
        run_instr(r_ins(5'd10, 5'd11, 5'd12, 6'h20), 0, "add_ovf");
        run_instr(i_ins(6'h08, 5'd10, 5'd13, 16'h0001), 0, "addi_ovf");
        run_instr(i_ins(6'h08, 5'd0, 5'd14, 16'hFFFE), 0, "addi_m2");
        run_instr(r_ins(5'd14, 5'd10, 5'd15, 6'h22), 0, "sub_ovf");
    endtask

    task automatic test_random;
        logic [5:0]  fns [5];
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op;
        logic [31:0] w;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        for (int k = 0; k < 120; k++) begin
            rs = 5'($urandom_range(0, 7));
            rt = ($urandom_range(0, 2) == 0) ? rs : 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1: w = r_ins(rs, rt, rd, fns[$urandom_range(0, 4)]);
                2:    w = i_ins(6'h08, rs, rt, 16'($urandom));
                3:    w = i_ins(6'h23, rs, rt, 16'($urandom_range(0, 15) * 4));
                4:    w = i_ins(6'h2B, rs, rt, 16'($urandom_range(0, 15) * 4));
                5:    w = i_ins(6'h04, rs, rt, 16'($urandom_range(0, 16) - 8));
                6: begin
                    op = 6'($urandom_range(0, 63));
                    if (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04)
                        op = 6'h3F;
                    w = {op, 26'($urandom)};
                end
                default: w = i_ins(6'h08, rs, rt, 16'($urandom_range(0, 40)));
            endcase
            run_instr(w, $urandom_range(0, 4), $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_reset_in_mem;
        int n;
        bit saw_ret;
        @(negedge clk);
        ins_valid = 1'b1;
        ins = i_ins(6'h23, 5'd0, 5'd2, 16'h0004);
        @(posedge clk);
        @(negedge clk);
        ins_valid = 1'b0;
        n = 0;
        while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_total++;
        if (dmem_req !== 1'b1) $display("FAIL rst_mem_entry: got req=%b want 1", dmem_req);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (dmem_req !== 1'b0 || retire !== 1'b0 || pc !== 32'd0)
            $display("FAIL rst_mem_abort: got req=%b ret=%b pc=%h want 0 0 0", dmem_req, retire, pc);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        saw_ret = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (retire === 1'b1 || dmem_req === 1'b1) saw_ret = 1;
        end
        n_total++;
        if (saw_ret || ins_ready !== 1'b1)
            $display("FAIL rst_mem_after: got activity=%b ready=%b want 0 1", saw_ret, ins_ready);
        else n_pass++;
        check_regs("rst_mem");
        run_instr(32'h20010005, 1, "post_reset_addi");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal_r0();
        test_overflow();
        test_random();
        test_reset_in_mem();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
